// File: rtl/ppu_palette_arbiter.sv
// ppu_palette_arbiter: shares the palette memory between render lookups (fixed priority) and a queued CPU FIFO.
// Optional macro PAL_ARB_FORCE_GRANT_EN lets a starved CPU head pre-empt one render lookup.
module ppu_palette_arbiter #(
    parameter int Q_DEPTH      = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       render_req,
    input  logic [4:0] render_addr,
    output logic [7:0] render_color,
    output logic       render_valid,
    input  logic       cpu_req,
    input  logic       cpu_rw,
    input  logic [4:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic       cpu_full,
    output logic [7:0] cpu_rdata,
    output logic       cpu_rvalid,
    output logic [4:0] pal_addr,
    output logic [7:0] pal_wdata,
    output logic       pal_rw,
    output logic       pal_en,
    input  logic [7:0] pal_color_in,
    output logic       starve_err
);
    localparam int PW = $clog2(Q_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [13:0]   fifo_q [Q_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] wait_q, wait_d;
    logic          full_q, empty, force_cpu, gnt_render, gnt_cpu;
    logic          render_valid_q, cpu_rvalid_q, starve_err_q;
    logic [7:0]    render_color_q, cpu_rdata_q;
    logic [13:0]   head;
    always_comb begin
        empty      = count_q == '0;
        head       = fifo_q[rd_ptr_q];
`ifdef PAL_ARB_FORCE_GRANT_EN
        force_cpu  = (wait_q == SW'(STARVE_LIMIT)) && !empty;
`else
        force_cpu  = 1'b0;
`endif
        gnt_render = render_req & ~force_cpu;
        gnt_cpu    = ~gnt_render & ~empty;
        cpu_ack    = cpu_req & ~full_q;
        pal_en     = gnt_render | gnt_cpu;
        pal_rw     = gnt_cpu & head[13];
        pal_addr   = gnt_render ? render_addr : gnt_cpu ? head[12:8] : 5'd0;
        pal_wdata  = pal_rw ? head[7:0] : 8'd0;
        count_d    = count_q + CW'(cpu_ack) - CW'(gnt_cpu);
        // Counter only runs while the head waits behind render traffic
        wait_d     = (gnt_cpu | empty) ? '0 :
                     (gnt_render && wait_q != SW'(STARVE_LIMIT)) ? wait_q + 1'b1 : wait_q;
    end
    always_ff @(posedge clk)
        if (cpu_ack) fifo_q[wr_ptr_q] <= {cpu_rw, cpu_addr, cpu_wdata};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            wait_q         <= '0;
            starve_err_q   <= 1'b0;
            render_valid_q <= 1'b0;
            render_color_q <= 8'h00;
            cpu_rvalid_q   <= 1'b0;
            cpu_rdata_q    <= 8'h00;
        end else begin
            wr_ptr_q       <= wr_ptr_q + PW'(cpu_ack);
            rd_ptr_q       <= rd_ptr_q + PW'(gnt_cpu);
            count_q        <= count_d;
            full_q         <= count_d == CW'(Q_DEPTH);
            wait_q         <= wait_d;
            starve_err_q   <= starve_err_q | (wait_d == SW'(STARVE_LIMIT));
            render_valid_q <= gnt_render;
            render_color_q <= gnt_render ? pal_color_in : render_color_q;
            cpu_rvalid_q   <= gnt_cpu & ~head[13];
            cpu_rdata_q    <= (gnt_cpu & ~head[13]) ? pal_color_in : cpu_rdata_q;
        end
    end
    assign cpu_full     = full_q;
    assign starve_err   = starve_err_q;
    assign render_valid = render_valid_q;
    assign render_color = render_color_q;
    assign cpu_rvalid   = cpu_rvalid_q;
    assign cpu_rdata    = cpu_rdata_q;
endmodule

// File: tb/tb_ppu_palette_arbiter.sv
// tb_ppu_palette_arbiter: directed and random stimulus against a queue-based reference model of the arbiter.
module tb_ppu_palette_arbiter;
    localparam int Q_DEPTH = 4;
    localparam int LIMIT   = 16;
`ifdef PAL_ARB_FORCE_GRANT_EN
    localparam bit FORCE = 1'b1;
`else
    localparam bit FORCE = 1'b0;
`endif
    typedef struct {
        logic       rw;
        logic [4:0] addr;
        logic [7:0] data;
    } req_t;
    logic clk = 1'b0, rst_n = 1'b0;
    logic render_req = 1'b0, cpu_req = 1'b0, cpu_rw = 1'b0;
    logic [4:0] render_addr = '0, cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic [7:0] render_color, cpu_rdata, pal_wdata, pal_color_in;
    logic render_valid, cpu_ack, cpu_full, cpu_rvalid, pal_rw, pal_en, starve_err;
    logic [4:0] pal_addr;
    logic [7:0] env_mem [32] = '{default: 8'h00};
    int checks = 0, failures = 0;
    req_t q[$];
    logic [7:0] ref_pal [32] = '{default: 8'h00};
    int m_wait = 0;
    bit m_starve = 0, exp_rv = 0, exp_cv = 0;
    logic [7:0] exp_rc = 8'h00, exp_cd = 8'h00;
    ppu_palette_arbiter #(.Q_DEPTH(Q_DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .render_req(render_req), .render_addr(render_addr),
        .render_color(render_color), .render_valid(render_valid),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_full(cpu_full), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .pal_addr(pal_addr), .pal_wdata(pal_wdata), .pal_rw(pal_rw), .pal_en(pal_en),
        .pal_color_in(pal_color_in), .starve_err(starve_err)
    );
    always #5 clk = ~clk;
    // Palette memory: combinational read, write at the clock edge
    assign pal_color_in = env_mem[pal_addr];
    always @(posedge clk) if (pal_en && pal_rw) env_mem[pal_addr] <= pal_wdata;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic check_regs();
        check("render_valid", 32'(render_valid), 32'(exp_rv));
        check("render_color", 32'(render_color), 32'(exp_rc));
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_cv));
        check("cpu_rdata", 32'(cpu_rdata), 32'(exp_cd));
        check("cpu_full", 32'(cpu_full), 32'(q.size() == Q_DEPTH));
        check("starve_err", 32'(starve_err), 32'(m_starve));
    endtask
    task automatic step(input logic rr, input logic [4:0] ra, input logic cr, input logic crw,
                        input logic [4:0] ca, input logic [7:0] cd);
        bit frc, gr, gc, acc;
        int sz;
        req_t h;
        @(negedge clk);
        check_regs();
        render_req = rr; render_addr = ra; cpu_req = cr; cpu_rw = crw; cpu_addr = ca; cpu_wdata = cd;
        #1;
        sz  = q.size();
        frc = FORCE && m_wait == LIMIT && sz > 0;
        gr  = rr && !frc;
        gc  = !gr && sz > 0;
        acc = cr && sz < Q_DEPTH;
        check("cpu_ack", 32'(cpu_ack), 32'(acc));
        check("pal_en", 32'(pal_en), 32'(gr || gc));
        check("pal_rw", 32'(pal_rw), 32'(gc && q[0].rw));
        check("pal_addr", 32'(pal_addr), gr ? 32'(ra) : gc ? 32'(q[0].addr) : 32'd0);
        check("pal_wdata", 32'(pal_wdata), (gc && q[0].rw) ? 32'(q[0].data) : 32'd0);
        exp_rv = gr;
        if (gr) exp_rc = ref_pal[ra];
        exp_cv = 0;
        if (gc) begin
            h = q.pop_front();
            if (h.rw) ref_pal[h.addr] = h.data;
            else begin
                exp_cv = 1;
                exp_cd = ref_pal[h.addr];
            end
        end
        if (acc) q.push_back('{crw, ca, cd});
        if (gc || sz == 0) m_wait = 0;
        else if (gr && m_wait < LIMIT) m_wait++;
        if (m_wait == LIMIT) m_starve = 1;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask
    initial begin
        @(negedge clk);
        check_regs();
        check("rst_pal_en", 32'(pal_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // CPU write then read back
        step(0, 0, 1, 1, 5'h01, 8'h29);
        step(0, 0, 1, 0, 5'h01, 8'h00);
        idle(2);
        // Render lookup sees the old value while a write to the same address waits
        step(0, 0, 1, 1, 5'h03, 8'h0F);
        idle(1);
        step(0, 0, 1, 1, 5'h03, 8'h33);
        step(1, 5'h03, 0, 0, 0, 0);
        idle(2);
        // Fill the FIFO under render pressure, fifth request is refused
        for (int i = 0; i < 5; i++) step(1, 5'(i), 1, 1, 5'(8 + i), 8'(3 * i + 1));
        check("full_hold", 32'(cpu_full), 32'd1);
        idle(6);
        // Starvation with a queued read
        step(1, 5'h02, 1, 0, 5'h09, 0);
        for (int i = 0; i < 17; i++) step(1, 5'(i), 0, 0, 0, 0);
        idle(3);
        check("starve_hold", 32'(starve_err), 32'd1);
        // Random traffic at several render loads
        for (int s = 0; s < 3000; s++) begin
            int pct;
            pct = (s / 250) % 3 == 0 ? 20 : (s / 250) % 3 == 1 ? 60 : 97;
            step($urandom_range(0, 99) < pct, 5'($urandom), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, 5'($urandom), 8'($urandom));
        end
        // Reset in the cycle a CPU read is granted
        step(1, 0, 1, 0, 5'h05, 0);
        idle(0);
        @(negedge clk);
        check_regs();
        render_req = 0; cpu_req = 0;
        #1;
        check("pre_rst_grant", 32'(pal_en && !pal_rw), 32'(q.size() > 0 && !q[0].rw));
        rst_n = 1'b0;
        #1;
        q.delete();
        m_wait = 0; m_starve = 0; exp_rv = 0; exp_cv = 0; exp_rc = 8'h00; exp_cd = 8'h00;
        check_regs();
        check("rst_pal_en2", 32'(pal_en), 32'd0);
        check("rst_pal_addr", 32'(pal_addr), 32'd0);
        check("rst_pal_wdata", 32'(pal_wdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        @(negedge clk);
        check_regs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
